fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, is the instruction queue depth; only the value 2 is supported.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 Port redirect_valid  input  1  branch/jump taken in decode this cycle.
REQ-006 Port redirect_pc  input  32  target address; bits [1:0] ignored and treated as 00.
REQ-007 Port imem_req  output  1  one-cycle fetch request pulse, always accepted by memory.
REQ-008 Port imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-009 Port imem_ack  input  1  one-cycle pulse returning data for the single outstanding request, at least 1 cycle after imem_req.
REQ-010 Port imem_rdata  input  32  instruction word, valid while imem_ack=1.
REQ-011 Port out_valid  output  1  queue head holds a valid instruction.
REQ-012 Port out_ready  input  1  decode accepts the head; a transfer occurs when out_valid=1 and out_ready=1.
REQ-013 Port out_instr  output  32  queue head instruction.
REQ-014 Port out_pc  output  32  address of the queue-head instruction.
REQ-015 Port out_pc4  output  32  out_pc+4, modulo 2^32.

Function
REQ-016 The FSM SHALL have states REQ (issue), WAIT (request outstanding) and DROP (outstanding request squashed).
REQ-017 In REQ, imem_req=1 with imem_addr=pc when queue count<2 and redirect_valid=0; the FSM then goes to WAIT, otherwise it stays in REQ with imem_req=0.
REQ-018 At most one request SHALL be outstanding, so the queue never overflows.
REQ-019 In WAIT, on imem_ack: push {pc, imem_rdata}, set pc<=pc+4 (wrapping at 2^32), and go to REQ.
REQ-020 In DROP, on imem_ack: discard the data and go to REQ; pc is unchanged.
REQ-021 redirect_valid=1 in any state: flush the queue, set pc<={redirect_pc[31:2],2'b00}; WAIT goes to DROP, DROP stays in DROP, REQ stays in REQ.
REQ-022 Redirect in WAIT in the same cycle as imem_ack: discard the ack data and go to REQ (not DROP).
REQ-023 Redirect in the same cycle as a transfer: redirect wins; the queue becomes empty.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-025 When the queue is empty, out_valid=0 and out_instr=out_pc=0.
REQ-026 Minimum latency: imem_req in cycle N, imem_ack in N+1, out_valid=1 in N+2.
REQ-027 With single-cycle ack and out_ready held at 1, steady-state throughput SHALL be one instruction per 2 cycles.

Reset
REQ-028 While reset=0: pc=RESET_PC, state=REQ, queue empty, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-029 Reset asserted mid-operation SHALL abandon any outstanding request; an imem_ack arriving after deassertion without a new request SHALL be ignored.
REQ-030 The first imem_req SHALL occur in the first clock cycle after reset deasserts.

Structure
REQ-031 Shared package mips_pkg SHALL hold the RESET_PC default, the fetch state encoding (REQ, WAIT, DROP), and the 32-bit word width constant.
REQ-032 The queue SHALL be a sub-module fetch_queue: 2-entry FIFO, 64-bit entries {pc, instr}, with push, pop, flush, count, and head outputs.

Verification
REQ-033 Reset release, ack 1 cycle after each req, out_ready=1 -> out_pc sequence 0x3000, 0x3004, 0x3008 with matching out_instr; out_pc4 = out_pc+4.
REQ-034 out_ready=0 for 10 cycles -> exactly 2 entries queued (0x3000, 0x3004), no further imem_req; releasing out_ready delivers both in order.
REQ-035 redirect_pc=0x3041 while in WAIT, ack next cycle -> ack data dropped, next imem_addr=0x3040, first delivered out_pc=0x3040.
REQ-036 Redirect coincident with imem_ack -> data dropped, next cycle imem_req with imem_addr=target, no DROP state entered.
REQ-037 pc=0xFFFF_FFFC via redirect -> out_pc4=0x0000_0000, next fetch address 0x0000_0000.
REQ-038 reset pulsed low during WAIT, stray ack afterwards -> no push; out_pc restarts at 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the default reset PC, the data word width, the fetch FSM state
// encoding and the packed {pc, instr} entry stored in the fetch queue.
package mips_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // REQ: may issue a fetch; WAIT: one request outstanding;
  // DROP: the outstanding request was squashed by a redirect.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (control state only)
//   i_push       write i_push_data at the tail (ignored when full)
//   i_push_data  64-bit {pc, instr} entry
//   i_pop        remove the head entry (ignored when empty)
//   i_flush      empty the queue; overrides push and pop
//   o_count      number of valid entries (0..2)
//   o_head       head entry, all-zero when the queue is empty
module fetch_queue
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2) && !i_flush;
  assign w_do_pop  = i_pop  && (r_count != 2'd0) && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, keeps
// at most one request outstanding, buffers returned words in a 2-entry
// queue and presents the head to decode with a valid/ready handshake.
// Ports:
//   clk, reset               clock and asynchronous active-low reset
//   redirect_valid/_pc       taken branch/jump from decode; flushes and
//                            retargets fetch (pc bits [1:0] ignored)
//   imem_req/_addr           one-cycle fetch request and word address
//   imem_ack/_rdata          one-cycle response for the outstanding request
//   out_valid/_ready         decode handshake on the queue head
//   out_instr/_pc/_pc4       head instruction, its address, address + 4
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_pc4
);

  localparam logic [1:0] QMAX = 2'(QDEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [WORD_W-1:0] r_pc;

  logic         w_room;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;
  logic         w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign w_room          = (w_count < QMAX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_REQ;
    else        r_state <= w_next_state;
  end

  // Next-state logic. An ack always closes the outstanding request, so a
  // redirect coinciding with an ack returns to REQ rather than DROP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_REQ: begin
        if (!redirect_valid && w_room) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack)            w_next_state = ST_REQ;
        else if (redirect_valid) w_next_state = ST_DROP;
      end
      ST_DROP: begin
        if (imem_ack) w_next_state = ST_REQ;
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  // Output logic. Request is masked by reset so nothing is issued while held.
  always_comb begin
    imem_req = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_flush  = redirect_valid;
    case (r_state)
      ST_REQ:  imem_req = reset && w_room && !redirect_valid;
      ST_WAIT: w_push   = imem_ack && !redirect_valid;
      default: ;
    endcase
    // A redirect flushes the queue, so it wins over a coincident transfer.
    w_pop = out_valid && out_ready && !redirect_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_pc[WORD_W-1:2], 2'b00};
    else if (w_push)         r_pc <= r_pc + 32'd4;
  end

  assign imem_addr         = r_pc;
  assign w_push_data.pc    = r_pc;
  assign w_push_data.instr = imem_rdata;

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign out_valid = (w_count != 2'd0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign out_pc4   = w_head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  int          tests  = 0;
  int          failed = 0;
  bit          auto_ack;
  logic        pend;
  logic [31:0] pend_addr;
  int          req_cnt;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One clock: optional memory response to last cycle's request, sample the
  // request, clock edge, then drop one-cycle pulses and let outputs settle.
  task automatic step();
    logic        nreq;
    logic [31:0] naddr;
    if (auto_ack) begin
      imem_ack   = pend;
      imem_rdata = pend ? instr_of(pend_addr) : 32'h0;
    end
    #1;
    nreq  = imem_req;
    naddr = imem_addr;
    if (nreq) req_cnt++;
    @(posedge clk);
    #1;
    pend           = nreq;
    pend_addr      = naddr;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    out_ready      = 1'b0;
    auto_ack       = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b1;
    pend    = 1'b0;
    req_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; out_ready = 1'b1; auto_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rst_req got %b exp 0", imem_req); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin failed++; $display("FAIL rst_instr got %h exp 0", out_instr); end
    tests++; if (out_pc !== 32'h0) begin failed++; $display("FAIL rst_pc got %h exp 0", out_pc); end
    reset = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL rel_req got %b exp 1", imem_req); end
    tests++; if (imem_addr !== 32'h3000) begin failed++; $display("FAIL rel_addr got %h exp 00003000", imem_addr); end
  endtask

  task automatic test_sequence();
    logic [31:0] gpc [3];
    logic [31:0] gin [3];
    logic [31:0] gp4 [3];
    int          at  [3];
    int          n = 0;
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      step();
      if (out_valid) begin
        gpc[n] = out_pc; gin[n] = out_instr; gp4[n] = out_pc4; at[n] = c; n++;
      end
    end
    tests++;
    if (n != 3) begin
      failed++; $display("FAIL seq_count got %0d exp 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (gpc[i] !== 32'h3000 + 32'(4*i)) begin failed++; $display("FAIL seq_pc[%0d] got %h exp %h", i, gpc[i], 32'h3000 + 32'(4*i)); end
        tests++; if (gin[i] !== instr_of(32'h3000 + 32'(4*i))) begin failed++; $display("FAIL seq_instr[%0d] got %h exp %h", i, gin[i], instr_of(32'h3000 + 32'(4*i))); end
        tests++; if (gp4[i] !== 32'h3004 + 32'(4*i)) begin failed++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, gp4[i], 32'h3004 + 32'(4*i)); end
      end
      tests++; if (at[0] != 1) begin failed++; $display("FAIL seq_latency got %0d exp 1", at[0]); end
      tests++; if (at[1] - at[0] != 2) begin failed++; $display("FAIL seq_rate got %0d exp 2", at[1] - at[0]); end
      tests++; if (at[2] - at[1] != 2) begin failed++; $display("FAIL seq_rate2 got %0d exp 2", at[2] - at[1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1;
    repeat (10) step();
    tests++; if (req_cnt != 2) begin failed++; $display("FAIL bp_reqs got %0d exp 2", req_cnt); end
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin failed++; $display("FAIL bp_head got %b/%h exp 1/00003000", out_valid, out_pc); end
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL bp_noreq got %b exp 0", imem_req); end
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_instr !== instr_of(32'h3004)) begin
      failed++; $display("FAIL bp_second got %b/%h/%h exp 1/00003004/%h", out_valid, out_pc, out_instr, instr_of(32'h3004)); end
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_push_pop();
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3004) begin failed++; $display("FAIL pp_head got %b/%h exp 1/00003004", out_valid, out_pc); end
    step();
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3008) begin failed++; $display("FAIL pp_next got %b/%h exp 1/00003008", out_valid, out_pc); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h3041;
    step();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rw_drop_req got %b exp 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rw_dropped got %b exp 0", out_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin failed++; $display("FAIL rw_refetch got %b/%h exp 1/00003040", imem_req, imem_addr); end
    auto_ack = 1'b1;
    step(); step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 || out_instr !== instr_of(32'h3040)) begin
      failed++; $display("FAIL rw_first got %b/%h/%h exp 1/00003040/%h", out_valid, out_pc, out_instr, instr_of(32'h3040)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b0;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0002;
    redirect_valid = 1'b1; redirect_pc = 32'h5008;
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL ra_dropped got %b exp 0", out_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h5008) begin failed++; $display("FAIL ra_req got %b/%h exp 1/00005008", imem_req, imem_addr); end
    auto_ack = 1'b1;
    step(); step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h5008) begin failed++; $display("FAIL ra_first got %b/%h exp 1/00005008", out_valid, out_pc); end
  endtask

  task automatic test_flush_transfer();
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1;
    repeat (4) step();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h7000;
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL fl_empty got %b exp 0", out_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h7000) begin failed++; $display("FAIL fl_req got %b/%h exp 1/00007000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wr_req got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
    step(); step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc4 !== 32'h0) begin
      failed++; $display("FAIL wr_head got %b/%h/%h exp 1/fffffffc/00000000", out_valid, out_pc, out_pc4); end
    tests++; if (out_instr !== instr_of(32'hFFFF_FFFC)) begin failed++; $display("FAIL wr_instr got %h exp %h", out_instr, instr_of(32'hFFFF_FFFC)); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("FAIL wr_next got %b/%h exp 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b1;
    repeat (3) step();
    auto_ack = 1'b0;
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failed++; $display("FAIL rm_clear got %b/%b exp 0/0", out_valid, imem_req); end
    step();
    reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rm_stray got %b exp 0", out_valid); end
    imem_ack = 1'b1; imem_rdata = instr_of(32'h3000);
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== instr_of(32'h3000)) begin
      failed++; $display("FAIL rm_restart got %b/%h/%h exp 1/00003000/%h", out_valid, out_pc, out_instr, instr_of(32'h3000)); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_push_pop();
    test_redirect_wait();
    test_redirect_ack();
    test_flush_transfer();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
